// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating counters, target buffer, mispredict flush.
// Define BP_TAG_EN to store and compare the upper PC bits as a tag; otherwise aliased PCs share.
module branch_predictor #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            resolve_valid,
  input  logic [PC_W-1:0] resolve_pc,
  input  logic            resolve_taken,
  input  logic [PC_W-1:0] resolve_target,
  input  logic            resolve_pred_taken,
  input  logic [PC_W-1:0] resolve_pred_target,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic            valid_q [ENTRIES];
  logic            valid_d [ENTRIES];
  logic [1:0]      cnt_q   [ENTRIES];
  logic [1:0]      cnt_d   [ENTRIES];
  logic [PC_W-1:0] tgt_q   [ENTRIES];
  logic [PC_W-1:0] tgt_d   [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IdxW-1:0] lookup_idx;
  logic [IdxW-1:0] resolve_idx;
  logic            lookup_tag_ok;
  logic            resolve_tag_ok;
  logic            resolve_hit;
  logic            table_we;
  logic            alloc_en;
  logic            mispredict;

  assign lookup_idx  = lookup_pc[2 +: IdxW];
  assign resolve_idx = resolve_pc[2 +: IdxW];

`ifdef BP_TAG_EN
  if (PC_W > 2 + IdxW) begin : g_tag
    localparam int unsigned TagW = PC_W - 2 - IdxW;

    logic [TagW-1:0] tag_q [ENTRIES];
    logic [TagW-1:0] tag_d [ENTRIES];

    always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
        tag_d[i] = tag_q[i];
      end
      if (alloc_en) begin
        tag_d[resolve_idx] = resolve_pc[PC_W-1 -: TagW];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < ENTRIES; i++) begin
          tag_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          tag_q[i] <= tag_d[i];
        end
      end
    end

    assign lookup_tag_ok  = (tag_q[lookup_idx] == lookup_pc[PC_W-1 -: TagW]);
    assign resolve_tag_ok = (tag_q[resolve_idx] == resolve_pc[PC_W-1 -: TagW]);
  end else begin : g_no_tag
    assign lookup_tag_ok  = 1'b1;
    assign resolve_tag_ok = 1'b1;
  end
`else
  assign lookup_tag_ok  = 1'b1;
  assign resolve_tag_ok = 1'b1;
`endif

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = lookup_pc + PC_W'(4);
    if (!rst) begin
      pred_hit   = valid_q[lookup_idx] & lookup_tag_ok;
      pred_taken = pred_hit & cnt_q[lookup_idx][1];
      if (pred_taken) begin
        pred_target = tgt_q[lookup_idx];
      end
    end
  end

  always_comb begin
    mispredict  = resolve_valid &
                  ((resolve_taken != resolve_pred_taken) |
                   (resolve_taken & (resolve_target != resolve_pred_target)));
    flush       = mispredict;
    redirect_pc = resolve_taken ? resolve_target : resolve_pc + PC_W'(4);
  end

  assign table_we    = resolve_valid & ~rst;
  assign resolve_hit = valid_q[resolve_idx] & resolve_tag_ok;
  assign alloc_en    = table_we & ~resolve_hit & resolve_taken;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i] = valid_q[i];
      cnt_d[i]   = cnt_q[i];
      tgt_d[i]   = tgt_q[i];
    end
    if (table_we && resolve_hit) begin
      if (resolve_taken) begin
        if (cnt_q[resolve_idx] != 2'd3) begin
          cnt_d[resolve_idx] = cnt_q[resolve_idx] + 2'd1;
        end
        tgt_d[resolve_idx] = resolve_target;
      end else if (cnt_q[resolve_idx] != 2'd0) begin
        cnt_d[resolve_idx] = cnt_q[resolve_idx] - 2'd1;
      end
    end else if (alloc_en) begin
      // New entries start weakly taken.
      valid_d[resolve_idx] = 1'b1;
      cnt_d[resolve_idx]   = 2'd2;
      tgt_d[resolve_idx]   = resolve_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'd0;
        tgt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= valid_d[i];
        cnt_q[i]   <= cnt_d[i];
        tgt_q[i]   <= tgt_d[i];
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve_valid && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
